// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
// Imported by the round-robin selector and the arbiter top.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_DBG  = 1'b1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port memory.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface dmem_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);

    logic              req0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [DATA_W-1:0] wdata0;
    logic              ack0;
    logic [DATA_W-1:0] rdata0;
    logic              err0;

    logic              req1;
    logic              we1;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata1;
    logic              ack1;
    logic [DATA_W-1:0] rdata1;
    logic              err1;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        output ack0, rdata0, err0,
        output ack1, rdata1, err1,
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        input  ack0, rdata0, err0,
        input  ack1, rdata1, err1,
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/dmem_arbiter_rr.sv
// Two-way request selector: a lone request wins outright; on a tie the port
// that did not win last time is chosen, or port 0 always when FIXED_PRIO is set.
module rr_arbiter2
    import dmem_arb_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic [1:0] req,
    input  logic       last_winner,
    output logic       grant_valid,
    output logic       grant_port
);

    always_comb begin
        grant_valid = |req;
        grant_port  = PORT_CORE;
        if (req == 2'b11) begin
            grant_port = (FIXED_PRIO != 0) ? PORT_CORE : ~last_winner;
        end else if (req[1]) begin
            grant_port = PORT_DBG;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between the core (port 0) and the debug
// loader (port 1): one three-cycle IDLE/ACCESS/RESP transaction per grant.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int DEPTH      = 64,
    parameter int FIXED_PRIO = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    dmem_arbiter_if.slave    bus,
    output logic             busy
);

    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(DEPTH * 4);

    state_t state;
    state_t state_next;

    logic              grant_valid;
    logic              grant_port;
    logic              rr_ptr;

    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_err;

    logic              lat_we;
    logic              lat_err;
    logic              lat_port;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;

    logic [DATA_W-1:0] rdata_q0;
    logic [DATA_W-1:0] rdata_q1;

    rr_arbiter2 #(
        .FIXED_PRIO (FIXED_PRIO)
    ) u_rr (
        .req         ({bus.req1, bus.req0}),
        .last_winner (rr_ptr),
        .grant_valid (grant_valid),
        .grant_port  (grant_port)
    );

    always_comb begin
        sel_we    = grant_port ? bus.we1    : bus.we0;
        sel_addr  = grant_port ? bus.addr1  : bus.addr0;
        sel_wdata = grant_port ? bus.wdata1 : bus.wdata0;
        sel_err   = (sel_addr[1:0] != 2'b00) || (sel_addr >= ADDR_LIMIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // RESP always returns to IDLE, so a request still held after its ack waits a full cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_valid) state_next = ACCESS;
            ACCESS:  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_we    <= 1'b0;
            lat_err   <= 1'b0;
            lat_port  <= PORT_CORE;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (state == IDLE && grant_valid) begin
            lat_we    <= sel_we;
            lat_err   <= sel_err;
            lat_port  <= grant_port;
            lat_addr  <= sel_addr;
            lat_wdata <= sel_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= PORT_CORE;
        end else if (state == RESP) begin
            rr_ptr <= lat_port;
        end
    end

    // Read data is captured on the same edge that commits a write, so writes return the old word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q0 <= '0;
            rdata_q1 <= '0;
        end else if (state == ACCESS) begin
            if (lat_port == PORT_DBG) begin
                rdata_q1 <= lat_err ? '0 : bus.mem_rdata;
            end else begin
                rdata_q0 <= lat_err ? '0 : bus.mem_rdata;
            end
        end
    end

    assign bus.mem_we    = (state == ACCESS) && lat_we && !lat_err;
    assign bus.mem_addr  = lat_addr;
    assign bus.mem_wdata = lat_wdata;

    assign bus.ack0   = (state == RESP) && (lat_port == PORT_CORE);
    assign bus.ack1   = (state == RESP) && (lat_port == PORT_DBG);
    assign bus.err0   = bus.ack0 && lat_err;
    assign bus.err1   = bus.ack1 && lat_err;
    assign bus.rdata0 = rdata_q0;
    assign bus.rdata1 = rdata_q1;

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a vector table of single transactions against
// a behavioural 64-word memory, plus contention, held-request and reset sequences.
module tb_dmem_arbiter;

    localparam int FIXED_PRIO = 0;

    typedef struct {
        logic        port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        chk_rdata;
        logic        exp_err;
        int          exp_we_cycles;
    } vec_t;

    logic clk;
    logic rst_n;
    logic busy;
    int   tests;
    int   errors;

    logic [31:0] mem [64];
    vec_t        vecs [10];

    dmem_arbiter_if #(.DATA_W(32), .ADDR_W(32)) bus ();

    dmem_arbiter #(
        .DATA_W     (32),
        .ADDR_W     (32),
        .DEPTH      (64),
        .FIXED_PRIO (FIXED_PRIO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] initWord(input int i);
        return 32'h1000_0000 + 32'(i);
    endfunction

    // Combinational-read, clocked-write memory model sitting beside the arbiter.
    initial begin
        for (int i = 0; i < 64; i++) mem[i] <= initWord(i);
        forever begin
            @(posedge clk);
            if (bus.mem_we) mem[bus.mem_addr[7:2]] <= bus.mem_wdata;
        end
    end
    assign bus.mem_rdata = mem[bus.mem_addr[7:2]];

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic driveReq(input logic port, input logic req, input logic we,
                            input logic [31:0] addr, input logic [31:0] wdata);
        if (port) begin
            bus.req1 = req; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wdata;
        end else begin
            bus.req0 = req; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wdata;
        end
    endtask

    // Runs one transaction from an idle, mid-cycle start; drops req as soon as ack is seen.
    task automatic applyStimulus(input vec_t v, output logic [31:0] rd, output logic er,
                                 output int ack_cyc, output int we_cyc, output int we_at,
                                 output int wrong_ack);
        rd = '0; er = 1'b0; ack_cyc = 0; we_cyc = 0; we_at = 0; wrong_ack = 0;
        driveReq(v.port, 1'b1, v.we, v.addr, v.wdata);
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk); #1;
            if (bus.mem_we) begin
                we_cyc++;
                we_at = n;
            end
            if (v.port ? bus.ack0 : bus.ack1) wrong_ack++;
            if (v.port ? bus.ack1 : bus.ack0) begin
                ack_cyc = n;
                rd = v.port ? bus.rdata1 : bus.rdata0;
                er = v.port ? bus.err1 : bus.err0;
                driveReq(v.port, 1'b0, 1'b0, 32'h0, 32'h0);
                break;
            end
        end
        driveReq(v.port, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          ack_cyc, we_cyc, we_at, wrong_ack;
        int          grants [4];
        int          n_grants, last_ack, gap_bad, both_bad, rdata_bad;
        int          held_acks, consec;
        logic        prev_ack;
        vec_t        v;

        tests = 0; errors = 0;
        rst_n = 1'b0;
        driveReq(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        driveReq(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);

        vecs[0] = '{1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 32'h1000_0004, 1'b1, 1'b0, 1};
        vecs[1] = '{1'b1, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF,  1'b1, 1'b0, 0};
        vecs[2] = '{1'b0, 1'b1, 32'h12,  32'h1111_1111, 32'h0,        1'b0, 1'b1, 0};
        vecs[3] = '{1'b1, 1'b1, 32'h100, 32'h2222_2222, 32'h0,        1'b0, 1'b1, 0};
        vecs[4] = '{1'b0, 1'b0, 32'h100, 32'h0,        32'h0,         1'b1, 1'b1, 0};
        vecs[5] = '{1'b1, 1'b0, 32'h12,  32'h0,        32'h0,         1'b1, 1'b1, 0};
        vecs[6] = '{1'b0, 1'b0, 32'hFC,  32'h0,        32'h1000_003F, 1'b1, 1'b0, 0};
        vecs[7] = '{1'b1, 1'b1, 32'hFC,  32'hCAFEF00D, 32'h1000_003F, 1'b1, 1'b0, 1};
        vecs[8] = '{1'b0, 1'b0, 32'hFC,  32'h0,        32'hCAFEF00D,  1'b1, 1'b0, 0};
        vecs[9] = '{1'b1, 1'b0, 32'h0,   32'h0,        32'h1000_0000, 1'b1, 1'b0, 0};

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_busy", 32'(busy), 32'h0);
        checkOutput("reset_ack", {30'h0, bus.ack1, bus.ack0}, 32'h0);
        checkOutput("reset_err", {30'h0, bus.err1, bus.err0}, 32'h0);
        checkOutput("reset_mem_we", 32'(bus.mem_we), 32'h0);
        checkOutput("reset_mem_addr", bus.mem_addr, 32'h0);
        checkOutput("reset_mem_wdata", bus.mem_wdata, 32'h0);
        checkOutput("reset_rdata0", bus.rdata0, 32'h0);
        checkOutput("reset_rdata1", bus.rdata1, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            v = vecs[i];
            applyStimulus(v, rd, er, ack_cyc, we_cyc, we_at, wrong_ack);
            checkOutput($sformatf("v%0d_ack_cycle", i), 32'(ack_cyc), 32'd2);
            checkOutput($sformatf("v%0d_wrong_ack", i), 32'(wrong_ack), 32'd0);
            checkOutput($sformatf("v%0d_err", i), 32'(er), 32'(v.exp_err));
            checkOutput($sformatf("v%0d_mem_we_cycles", i), 32'(we_cyc), 32'(v.exp_we_cycles));
            checkOutput($sformatf("v%0d_mem_we_at", i), 32'(we_at), 32'(v.exp_we_cycles));
            if (v.chk_rdata) checkOutput($sformatf("v%0d_rdata", i), rd, v.exp_rdata);
            @(posedge clk); #1;
            checkOutput($sformatf("v%0d_idle_after", i), {30'h0, busy, bus.ack0 | bus.ack1}, 32'h0);
        end

        checkOutput("mem_word4", mem[4], 32'hDEADBEEF);
        checkOutput("mem_word0", mem[0], initWord(0));
        checkOutput("mem_word63", mem[63], 32'hCAFEF00D);

        // Both ports held: grants must alternate and be spaced three cycles apart.
        for (int i = 0; i < 4; i++) grants[i] = -1;
        n_grants = 0; last_ack = 0; gap_bad = 0; both_bad = 0; rdata_bad = 0;
        driveReq(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
        driveReq(1'b1, 1'b1, 1'b0, 32'hFC, 32'h0);
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (bus.ack0 && bus.ack1) both_bad++;
            if (bus.ack0 || bus.ack1) begin
                if (n_grants > 0 && (n - last_ack) != 3) gap_bad++;
                last_ack = n;
                grants[n_grants] = bus.ack1 ? 1 : 0;
                if (bus.ack1 && bus.rdata1 !== 32'hCAFEF00D) rdata_bad++;
                if (!bus.ack1 && bus.rdata0 !== 32'hDEADBEEF) rdata_bad++;
                n_grants++;
                if (n_grants == 4) break;
            end
        end
        driveReq(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        driveReq(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("cont_count", 32'(n_grants), 32'd4);
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("cont_grant%0d", i), 32'(grants[i]),
                        32'((FIXED_PRIO != 0) ? 0 : (i % 2)));
        checkOutput("cont_gap", 32'(gap_bad), 32'd0);
        checkOutput("cont_both_ack", 32'(both_bad), 32'd0);
        checkOutput("cont_rdata", 32'(rdata_bad), 32'd0);
        @(posedge clk); #1;
        checkOutput("cont_idle_after", 32'(busy), 32'h0);

        // A request held across its ack is re-granted only after a full IDLE cycle.
        held_acks = 0; consec = 0; prev_ack = 1'b0;
        driveReq(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk); #1;
            if (bus.ack0) held_acks++;
            if (bus.ack0 && prev_ack) consec++;
            prev_ack = bus.ack0;
        end
        driveReq(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("held_ack_count", 32'(held_acks), 32'd4);
        checkOutput("held_consecutive", 32'(consec), 32'd0);
        checkOutput("held_end_idle", 32'(busy), 32'h0);

        // Reset in the ACCESS cycle of a write: nothing commits and no ack appears.
        driveReq(1'b0, 1'b1, 1'b1, 32'h20, 32'h55AA55AA);
        @(posedge clk); #1;
        checkOutput("rst_pre_mem_we", 32'(bus.mem_we), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_mem_we", 32'(bus.mem_we), 32'h0);
        checkOutput("rst_busy", 32'(busy), 32'h0);
        checkOutput("rst_ack", {30'h0, bus.ack1, bus.ack0}, 32'h0);
        checkOutput("rst_rdata0", bus.rdata0, 32'h0);
        checkOutput("rst_mem_addr", bus.mem_addr, 32'h0);
        driveReq(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        @(posedge clk); #1;
        checkOutput("rst_ack_during", {30'h0, bus.ack1, bus.ack0}, 32'h0);
        rst_n = 1'b1;
        checkOutput("rst_word8", mem[8], initWord(8));

        v = '{1'b1, 1'b0, 32'h20, 32'h0, 32'h1000_0008, 1'b1, 1'b0, 0};
        applyStimulus(v, rd, er, ack_cyc, we_cyc, we_at, wrong_ack);
        checkOutput("post_rst_ack_cycle", 32'(ack_cyc), 32'd2);
        checkOutput("post_rst_rdata", rd, 32'h1000_0008);
        checkOutput("post_rst_err", 32'(er), 32'h0);
        @(posedge clk); #1;
        checkOutput("post_rst_idle", 32'(busy), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
